serial_packer: RTL and testbench
================================

SERIAL_PACKER -- requirements
Module: serial_packer

Interface
REQ-001 Parameter WIDTH, default 8; bits per packed word; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; clears all state while low.
REQ-004 bit_in  input  1  serial data bit from the upstream Mealy FSM output.
REQ-005 bit_valid  input  1  bit_in is sampled only when high.
REQ-006 flush  input  1  synchronous; discards the partial word in progress.
REQ-007 word_ready  input  1  downstream ready to take word_out.
REQ-008 word_out  output  WIDTH  head packed word, first-received bit in MSB.
REQ-009 word_valid  output  1  word_out is valid.
REQ-010 word_ones  output  clog2(WIDTH+1)  count of 1 bits in word_out.
REQ-011 overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-012 Shifter: on each cycle with bit_valid=1 and flush=0, bit_in shifts into the LSB of the shift register and the bit counter increments.
REQ-013 Word completes in the cycle the WIDTH-th valid bit is accepted; the counter wraps to 0 in that same cycle.
REQ-014 The completed word is pushed into a 2-entry output buffer at that same edge; word_valid rises the following cycle (1-cycle latency from the last bit).
REQ-015 Buffer occupancy FSM states: EMPTY, ONE, FULL; word_valid = (state != EMPTY).
REQ-016 Transitions: push only -> +1; pop only (word_valid & word_ready) -> -1; push and pop together -> unchanged, order preserved.
REQ-017 Push while FULL with no pop in the same cycle: word dropped, buffer unchanged, overflow set to 1 and held until reset.
REQ-018 Push while FULL with a pop in the same cycle: accepted, no overflow.
REQ-019 word_out and word_valid are stable while word_valid=1 and word_ready=0.
REQ-020 word_ones is derived combinationally from the head entry; 0 when EMPTY.
REQ-021 word_out is 0 when EMPTY.
REQ-022 flush=1: shift register and bit counter clear; bit_valid is ignored that cycle; buffered words and overflow are unaffected.
REQ-023 bit_valid=0 cycles are gaps: the shifter holds and the bit counter holds.
REQ-024 word_ready while EMPTY has no effect.

Reset
REQ-025 While reset=0: bit counter=0, shift register=0, state=EMPTY, word_out=0, word_valid=0, word_ones=0, overflow=0.
REQ-026 Asserting reset mid-word or mid-handshake discards all partial and buffered data immediately, without waiting for a clock edge.
REQ-027 The first bit is accepted on the first rising edge after reset deasserts.

Structure
REQ-028 A shared package serial_packer_pkg holds the occupancy enum (EMPTY, ONE, FULL) and the default WIDTH constant.
REQ-029 The 2-entry buffer with its occupancy FSM is a sub-module named word_fifo2, parameterised by WIDTH.
REQ-030 The shifter, bit counter, overflow flag and popcount logic reside in serial_packer.

Verification
REQ-031 Feed 10110010 with bit_valid=1 and word_ready=0 -> one cycle after the 8th bit: word_valid=1, word_out=0xB2, word_ones=4.
REQ-032 Feed three words 0xFF, 0x01, 0x80 with word_ready=0 -> buffer holds 0xFF then 0x01; overflow=1 after the third word; popping yields 0xFF then 0x01, then word_valid=0.
REQ-033 Buffer FULL; the third word completes in a cycle with word_ready=1 -> overflow stays 0; the pop sequence is 0xFF, 0x01, 0x80.
REQ-034 Feed 101, pulse flush, then feed 11110000 -> word_out=0xF0; no bits from before the flush appear.
REQ-035 Interleave bit_valid=0 gaps between the bits of 0x5A -> word_out=0x5A, word_ones=4, same as gap-free.
REQ-036 Assert reset asynchronously (between clock edges) with 5 bits shifted and one word buffered -> all outputs are 0 immediately; the next 8 bits form a fresh word.

Source files
------------

// File: rtl/serial_packer_pkg.sv
// Shared types and defaults for the serial packer and its output buffer.
package serial_packer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/word_fifo2.sv
// Two-entry word buffer; head entry drives the output and reads zero when empty.
// state | meaning
// EMPTY | no word held, head reads 0
// ONE   | head valid, tail unused
// FULL  | head and tail valid, tail is the younger word
module word_fifo2
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full
);

  occ_e             r_state;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({i_push, i_pop})
            2'b11: r_head <= i_data;
            2'b10: begin
              r_tail  <= i_data;
              r_state <= FULL;
            end
            2'b01: begin
              r_head  <= '0;
              r_state <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          // push without pop is dropped here; the parent flags the overflow
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) begin
              r_tail <= i_data;
            end else begin
              r_tail  <= '0;
              r_state <= ONE;
            end
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_data  = r_head;
  assign o_valid = (r_state != EMPTY);
  assign o_full  = (r_state == FULL);

endmodule

// File: rtl/serial_packer.sv
// Packs a gated serial bit stream MSB-first into WIDTH-bit words and queues
// them in a two-entry buffer with a popcount of the head word.
module serial_packer
  import serial_packer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bit_in,
  input  logic                       bit_valid,
  input  logic                       flush,
  input  logic                       word_ready,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  output logic [$clog2(WIDTH+1)-1:0] word_ones,
  output logic                       overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int OW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [WIDTH-1:0] w_word;
  logic [OW-1:0]    w_ones;

  assign w_accept = bit_valid & ~flush;
  assign w_push   = w_accept & (r_cnt == CW'(WIDTH - 1));
  assign w_word   = {r_shift[WIDTH-2:0], bit_in};
  assign w_pop    = word_valid & word_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift    <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (bit_valid) begin
        r_shift <= w_word;
        r_cnt   <= w_push ? '0 : r_cnt + CW'(1);
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  word_fifo2 #(.WIDTH(WIDTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_data  (word_out),
    .o_valid (word_valid),
    .o_full  (w_full)
  );

  // head reads zero when empty, so the count falls to zero with it
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + OW'(word_out[i]);
    end
  end

  assign word_ones = w_ones;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_packer.sv
// Directed bench for serial_packer at WIDTH=8; inputs change and outputs are
// sampled on the falling edge.
module tb_serial_packer;

  logic       clk = 1'b0;
  logic       reset;
  logic       bit_in;
  logic       bit_valid;
  logic       flush;
  logic       word_ready;
  logic [7:0] word_out;
  logic       word_valid;
  logic [3:0] word_ones;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  serial_packer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .flush      (flush),
    .word_ready (word_ready),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ones  (word_ones),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic drive_bit(input logic b, input logic rdy);
    @(negedge clk);
    bit_in     = b;
    bit_valid  = 1'b1;
    flush      = 1'b0;
    word_ready = rdy;
  endtask

  task automatic idle();
    @(negedge clk);
    bit_valid  = 1'b0;
    flush      = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last);
    for (int i = 7; i >= 0; i--) drive_bit(w[i], (i == 0) ? rdy_last : 1'b0);
  endtask

  // checks the head word, then requests a pop on the following edge
  task automatic pop_expect(input string name, input logic [7:0] exp_w, input logic [3:0] exp_o);
    @(negedge clk);
    bit_valid = 1'b0;
    flush     = 1'b0;
    n_checks++;
    if (word_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL %s valid: got %b want 1", name, word_valid);
    end
    n_checks++;
    if (word_out !== exp_w) begin
      n_errors++;
      $display("FAIL %s word: got %h want %h", name, word_out, exp_w);
    end
    n_checks++;
    if (word_ones !== exp_o) begin
      n_errors++;
      $display("FAIL %s ones: got %0d want %0d", name, word_ones, exp_o);
    end
    word_ready = 1'b1;
  endtask

  task automatic expect_empty(input string name);
    @(negedge clk);
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    n_checks++;
    if (word_valid !== 1'b0 || word_out !== 8'h00 || word_ones !== 4'd0) begin
      n_errors++;
      $display("FAIL %s empty: got valid=%b word=%h ones=%0d want 0/00/0",
               name, word_valid, word_out, word_ones);
    end
  endtask

  task automatic check_ovf(input string name, input logic exp);
    n_checks++;
    if (overflow !== exp) begin
      n_errors++;
      $display("FAIL %s overflow: got %b want %b", name, overflow, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (word_valid !== 1'b0 || word_out !== 8'h00 || word_ones !== 4'd0) begin
      n_errors++;
      $display("FAIL reset outputs: got valid=%b word=%h ones=%0d want 0/00/0",
               word_valid, word_out, word_ones);
    end
    check_ovf("reset", 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] w;
    w = 8'b10110010;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i], 1'b0);
      if (i == 0) begin
        n_checks++;
        if (word_valid !== 1'b0) begin
          n_errors++;
          $display("FAIL basic early_valid: got %b want 0", word_valid);
        end
      end
    end
    pop_expect("basic", 8'hB2, 4'd4);
    expect_empty("basic");
  endtask

  task automatic test_overflow();
    send_word(8'hFF, 1'b0);
    send_word(8'h01, 1'b0);
    idle();
    check_ovf("ovf_two", 1'b0);
    send_word(8'h80, 1'b0);
    pop_expect("ovf_first", 8'hFF, 4'd8);
    check_ovf("ovf_set", 1'b1);
    pop_expect("ovf_second", 8'h01, 4'd1);
    expect_empty("ovf");
    check_ovf("ovf_sticky", 1'b1);
    do_reset();
  endtask

  task automatic test_full_pop();
    send_word(8'hFF, 1'b0);
    send_word(8'h01, 1'b0);
    send_word(8'h80, 1'b1);
    pop_expect("fullpop_second", 8'h01, 4'd1);
    check_ovf("fullpop", 1'b0);
    pop_expect("fullpop_third", 8'h80, 4'd1);
    expect_empty("fullpop");
  endtask

  task automatic test_flush();
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(negedge clk);
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    send_word(8'hF0, 1'b0);
    pop_expect("flush", 8'hF0, 4'd4);
    expect_empty("flush");
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h5A;
    for (int i = 7; i >= 0; i--) begin
      drive_bit(w[i], 1'b0);
      idle();
      if (i % 2 == 0) idle();
    end
    pop_expect("gaps", 8'h5A, 4'd4);
    expect_empty("gaps");
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    send_word(8'h3C, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b1, 1'b0);
    @(posedge clk);
    bit_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (word_valid !== 1'b0 || word_out !== 8'h00 || word_ones !== 4'd0) begin
      n_errors++;
      $display("FAIL async_reset outputs: got valid=%b word=%h ones=%0d want 0/00/0",
               word_valid, word_out, word_ones);
    end
    check_ovf("async_reset", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    w = 8'h96;
    for (int i = 7; i >= 0; i--) drive_bit(w[i], 1'b1);
    pop_expect("async_fresh", 8'h96, 4'd4);
    expect_empty("async_fresh");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_flush();
    test_gaps();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
